// File: rtl/fetch_unit_if.sv
// Fetch-side bus: redirect controls in from the core, PC/status out.
// The fetch unit connects through the master modport; the control/memory
// side (or a testbench) uses the slave modport.
interface fetch_unit_if;
    logic        Stall;
    logic        Halt;
    logic        Branch;
    logic        Branch_Not_Equal;
    logic        Zero;
    logic        Jump;
    logic        JR;
    logic [25:0] Inst_25_0;
    logic [15:0] Inst_15_0;
    logic [31:0] Read_Data_1;
    logic [12:0] PC_Out;
    logic [31:0] Link_Addr;
    logic        Fetch_Valid;
    logic        Halted;
    logic [31:0] Instr_Count;

    modport master (
        input  Stall, Halt, Branch, Branch_Not_Equal, Zero, Jump, JR,
        input  Inst_25_0, Inst_15_0, Read_Data_1,
        output PC_Out, Link_Addr, Fetch_Valid, Halted, Instr_Count
    );

    modport slave (
        output Stall, Halt, Branch, Branch_Not_Equal, Zero, Jump, JR,
        output Inst_25_0, Inst_15_0, Read_Data_1,
        input  PC_Out, Link_Addr, Fetch_Valid, Halted, Instr_Count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: 13-bit word-addressed PC with branch/jump/jr
// redirection, stall and halt handling, and an advance counter.
module fetch_unit (
    input  logic         Clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [12:0] pc_reg;
    logic [31:0] instr_count_reg;

    logic [12:0] pc_plus1;
    logic [12:0] branch_target;
    logic [12:0] pc_next;
    logic        branch_taken;

    // Only the low 13 bits of the sign-extended offset survive the mod-8192
    // add, so the upper offset bits, the jr byte-offset bits and the high
    // jump-field bits never influence the PC.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.Inst_15_0[15:13], bus.Inst_25_0[25:13],
                           bus.Read_Data_1[31:15], bus.Read_Data_1[1:0]};

    // Next-PC selection: jr beats jump beats taken branch beats sequential.
    always_comb begin
        pc_plus1      = pc_reg + 13'd1;
        branch_target = pc_plus1 + bus.Inst_15_0[12:0];
        branch_taken  = (bus.Branch & bus.Zero) | (bus.Branch_Not_Equal & ~bus.Zero);
        pc_next       = pc_plus1;
        if (bus.JR)
            pc_next = bus.Read_Data_1[14:2];
        else if (bus.Jump)
            pc_next = bus.Inst_25_0[12:0];
        else if (branch_taken)
            pc_next = branch_target;
    end

    // Control FSM with PC and counter; redirects are only consumed on RUN advances.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_reg       <= ST_INIT;
            pc_reg          <= 13'd0;
            instr_count_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.Halt) begin
                        state_reg <= ST_HALT;
                    end else if (bus.Stall) begin
                        state_reg <= ST_STALL;
                    end else begin
                        pc_reg          <= pc_next;
                        instr_count_reg <= instr_count_reg + 32'd1;
                    end
                end
                ST_STALL: begin
                    if (bus.Halt)
                        state_reg <= ST_HALT;
                    else if (!bus.Stall)
                        state_reg <= ST_RUN;
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.PC_Out      = pc_reg;
    assign bus.Link_Addr   = {17'd0, pc_plus1, 2'b00};
    assign bus.Fetch_Valid = (state_reg == ST_RUN);
    assign bus.Halted      = (state_reg == ST_HALT);
    assign bus.Instr_Count = instr_count_reg;

endmodule
